load_data_unit: RTL and testbench
=================================

LOAD_DATA_UNIT -- requirements
Module: load_data_unit

Interface
REQ-001 clk  input  1  single clock; all state on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  load request from execute stage.
REQ-004 req_ready  output  1  unit can accept a request.
REQ-005 addr  input  32  byte address of the load.
REQ-006 width  input  2  access width: 00 byte, 01 half-word, 10 word, 11 reserved.
REQ-007 unsigned_ld  input  1  1 = zero-extend (LBU/LHU), 0 = sign-extend.
REQ-008 mem_req  output  1  one-cycle read strobe to data memory.
REQ-009 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-010 mem_be  output  4  byte lanes read: byte 0001/0010/0100/1000 by offset; half 0011/1100 by addr[1]; word 1111.
REQ-011 mem_rvalid  input  1  read data valid.
REQ-012 mem_rdata  input  32  raw 32-bit memory word.
REQ-013 ld_valid  output  1  load result valid.
REQ-014 ld_ready  input  1  write-back accepts result.
REQ-015 ld_data  output  32  aligned, extended result.
REQ-016 ld_err  output  1  misaligned/reserved-width flag, valid with ld_valid.

Function
REQ-017 FSM states IDLE, REQ, WAIT, RESP; SHALL be a registered state.
REQ-018 IDLE: req_ready=1; on req_valid capture addr, width, unsigned_ld, go REQ; otherwise stay.
REQ-019 REQ: mem_req=1 with mem_addr/mem_be from captured request for exactly one cycle, then WAIT.
REQ-020 WAIT: on mem_rvalid register extracted data into ld_data, go RESP; otherwise stay indefinitely.
REQ-021 mem_rvalid outside WAIT SHALL be ignored.
REQ-022 Extraction: byte = mem_rdata[8*off+7 -: 8]; half = mem_rdata[16*addr[1]+15 -: 16]; word = mem_rdata.
REQ-023 Extension: sign-extend from bit 7/15 when unsigned_ld=0, zero-extend when 1; ignored for word.
REQ-024 RESP: ld_valid=1, ld_data/ld_err held stable; on ld_ready go IDLE.
REQ-025 req_ready=0 in REQ, WAIT, RESP; no request overlap; minimum accept-to-ld_valid latency 3 cycles.
REQ-026 mem_req, mem_be SHALL be 0 outside REQ; mem_addr SHALL hold the captured address.

Reset
REQ-027 rst asserted at any time SHALL force IDLE, ld_valid=0, ld_err=0, ld_data=0, mem_req=0, mem_be=0, mem_addr=0.
REQ-028 Reset mid-transaction SHALL discard the in-flight load; a late mem_rvalid SHALL be ignored.

Configuration
REQ-029 Macro LOAD_MISALIGN_CHK_EN: when defined, half with addr[0]=1, word with addr[1:0]!=0, or width=11 SHALL skip REQ/WAIT, go IDLE->RESP directly with ld_err=1, ld_data=0, no mem_req.
REQ-030 Without LOAD_MISALIGN_CHK_EN: ld_err tied 0; half ignores addr[0], word ignores addr[1:0], width=11 treated as word.

Structure
REQ-031 Shared package lsu_pkg SHALL hold width encoding constants (LSU_BYTE, LSU_HALF, LSU_WORD) and the load FSM state enum.
REQ-032 Combinational align/extend SHALL be sub-module load_extract (inputs rdata, offset, width, unsigned_ld; output 32-bit data).

Verification
REQ-033 LB addr 0x1003, mem_rdata 0x80FF1234 -> mem_addr 0x1000, mem_be 1000, ld_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-034 LH addr 0x2002, mem_rdata 0xABCD0000 -> mem_be 1100, ld_data 0xFFFFABCD; LHU -> 0x0000ABCD.
REQ-035 LW addr 0x3000, mem_rdata 0xDEADBEEF with mem_rvalid 2 cycles late -> mem_be 1111, ld_data 0xDEADBEEF, ld_valid after 5 cycles.
REQ-036 ld_ready held low 3 cycles in RESP -> ld_valid and ld_data stable, req_ready 0, new req_valid not accepted.
REQ-037 LW addr 0x4002 with LOAD_MISALIGN_CHK_EN -> no mem_req, ld_valid with ld_err=1, ld_data 0; without macro -> mem_addr 0x4000, ld_err 0.
REQ-038 rst pulsed in WAIT, then mem_rvalid -> FSM IDLE, ld_valid stays 0, req_ready 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load path of the LSU.
// Holds the access-width encoding, the load FSM state type and small
// address/width helpers used by the load data unit.
package lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;
  localparam int unsigned LSU_NBE  = LSU_XLEN / 8;

  // Access width encoding on the width input
  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;
  localparam logic [1:0] LSU_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } ld_state_t;

  // Byte-lane mask for a load; the reserved width reads the whole word
  function automatic logic [LSU_NBE-1:0] lsu_be(input logic [1:0] off, input logic [1:0] wd);
    logic [LSU_NBE-1:0] be;
    case (wd)
      LSU_BYTE: be = 4'b0001 << off;
      LSU_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Misaligned half/word or reserved width
  function automatic logic lsu_misaligned(input logic [1:0] off, input logic [1:0] wd);
    logic bad;
    case (wd)
      LSU_HALF: bad = off[0];
      LSU_WORD: bad = (off != 2'b00);
      LSU_RSVD: bad = 1'b1;
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a raw memory word.
// Ports:
//   rdata       in  32  raw memory word
//   offset      in  2   byte offset of the load within the word
//   width       in  2   access width (byte/half/word; reserved reads as word)
//   unsigned_ld in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  aligned, extended result
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        unsigned_ld,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, half by offset[1] only
  assign w_byte = rdata[{offset, 3'b000} +: 8];
  assign w_half = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (width)
      LSU_BYTE: data = unsigned_ld ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      LSU_HALF: data = unsigned_ld ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Load data unit: accepts one load from execute, issues a single-cycle
// word-aligned read to data memory, aligns/extends the returned data and
// holds the result until write-back takes it.
// Optional feature macro: LOAD_MISALIGN_CHK_EN -- misaligned half/word and
// reserved-width loads skip memory and respond immediately with ld_err=1.
// Ports:
//   clk, rst            clock, async active-high reset
//   req_valid/req_ready load request handshake from execute
//   addr, width, unsigned_ld  request payload
//   mem_req, mem_addr, mem_be  read strobe, aligned address, byte lanes
//   mem_rvalid, mem_rdata      read return
//   ld_valid/ld_ready    result handshake to write-back
//   ld_data, ld_err      result payload
module load_data_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic        unsigned_ld,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  input  logic        ld_ready,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  ld_state_t   r_state, w_state_nxt;

  logic        r_req_ready, w_req_ready_nxt;
  logic        r_mem_req,   w_mem_req_nxt;
  logic [31:0] r_mem_addr,  w_mem_addr_nxt;
  logic [3:0]  r_mem_be,    w_mem_be_nxt;
  logic        r_ld_valid,  w_ld_valid_nxt;
  logic [31:0] r_ld_data,   w_ld_data_nxt;
  logic        r_ld_err,    w_ld_err_nxt;

  // Captured request fields needed after acceptance
  logic [1:0]  r_off;
  logic [1:0]  r_width;
  logic        r_unsigned;
  logic        w_capture;

  logic        w_bad;
  logic [31:0] w_ext_data;

`ifdef LOAD_MISALIGN_CHK_EN
  assign w_bad = lsu_misaligned(addr[1:0], width);
`else
  assign w_bad = 1'b0;
`endif

  load_extract u_extract (
    .rdata       (mem_rdata),
    .offset      (r_off),
    .width       (r_width),
    .unsigned_ld (r_unsigned),
    .data        (w_ext_data)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_mem_req_nxt   = 1'b0;
    w_mem_be_nxt    = 4'h0;
    w_mem_addr_nxt  = r_mem_addr;
    w_ld_valid_nxt  = r_ld_valid;
    w_ld_data_nxt   = r_ld_data;
    w_ld_err_nxt    = r_ld_err;
    w_capture       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid) begin
          w_capture       = 1'b1;
          w_req_ready_nxt = 1'b0;
          w_mem_addr_nxt  = {addr[31:2], 2'b00};
          if (w_bad) begin
            // Rejected access: respond at once without touching memory
            w_state_nxt    = ST_RESP;
            w_ld_valid_nxt = 1'b1;
            w_ld_err_nxt   = 1'b1;
            w_ld_data_nxt  = 32'h0;
          end else begin
            w_state_nxt   = ST_REQ;
            w_mem_req_nxt = 1'b1;
            w_mem_be_nxt  = lsu_be(addr[1:0], width);
          end
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt    = ST_RESP;
          w_ld_valid_nxt = 1'b1;
          w_ld_err_nxt   = 1'b0;
          w_ld_data_nxt  = w_ext_data;
        end
      end
      ST_RESP: begin
        if (ld_ready) begin
          w_state_nxt     = ST_IDLE;
          w_ld_valid_nxt  = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
        w_ld_valid_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_ld_valid  <= 1'b0;
      r_ld_data   <= 32'h0;
      r_ld_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_ld_valid  <= w_ld_valid_nxt;
      r_ld_data   <= w_ld_data_nxt;
      r_ld_err    <= w_ld_err_nxt;
    end
  end

  // Request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_off      <= 2'b00;
      r_width    <= LSU_BYTE;
      r_unsigned <= 1'b0;
    end else if (w_capture) begin
      r_off      <= addr[1:0];
      r_width    <= width;
      r_unsigned <= unsigned_ld;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign ld_valid  = r_ld_valid;
  assign ld_data   = r_ld_data;
  assign ld_err    = r_ld_err;

endmodule

// File: tb/tb_load_data_unit.sv
// Testbench for load_data_unit: directed loads with literal expectations plus
// randomized loads, all outputs compared every cycle against a
// transaction-level reference model. Honours LOAD_MISALIGN_CHK_EN.
module tb_load_data_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'h0;
  logic [1:0]  width = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        ld_valid;
  logic        ld_ready = 1'b0;
  logic [31:0] ld_data;
  logic        ld_err;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  load_data_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .addr        (addr),
    .width       (width),
    .unsigned_ld (unsigned_ld),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_err      (ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference functions ----------------
  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] w, logic u, logic [31:0] rd);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (w == 2'd0) begin
      v = (rd >> (8 * off)) & 32'h0000_00FF;
      if (!u && (v & 32'h80) != 0) v = v | 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!u && (v & 32'h8000) != 0) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(logic [31:0] a, logic [1:0] w);
    int unsigned off;
    off = a % 4;
    if (w == 2'd0) return 4'(1 << off);
    if (w == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic ref_bad(logic [31:0] a, logic [1:0] w);
`ifdef LOAD_MISALIGN_CHK_EN
    int unsigned off;
    off = a % 4;
    return (w == 2'd1 && off % 2 != 0) || (w == 2'd2 && off != 0) || (w == 2'd3);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- transaction-level model ----------------
  // ph: 0 idle, 1 read issued, 2 awaiting data, 3 result held
  int          ph;
  logic [31:0] ca;
  logic [1:0]  cw;
  logic        cu;
  logic        e_ready, e_mreq, e_valid, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_maddr, e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; e_ready = 1'b1; e_mreq = 1'b0; e_be = 4'h0; e_maddr = 32'h0;
      e_valid = 1'b0; e_err = 1'b0; e_data = 32'h0;
    end else begin
      e_mreq = 1'b0;
      e_be   = 4'h0;
      if (ph == 0) begin
        if (req_valid) begin
          ca = addr; cw = width; cu = unsigned_ld;
          e_maddr = addr & 32'hFFFF_FFFC;
          e_ready = 1'b0;
          if (ref_bad(addr, width)) begin
            ph = 3; e_valid = 1'b1; e_err = 1'b1; e_data = 32'h0;
          end else begin
            ph = 1; e_mreq = 1'b1; e_be = ref_be(addr, width);
          end
        end
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2) begin
        if (mem_rvalid) begin
          ph = 3; e_valid = 1'b1; e_err = 1'b0; e_data = ref_load(ca, cw, cu, mem_rdata);
        end
      end else begin
        if (ld_ready) begin
          ph = 0; e_valid = 1'b0; e_ready = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("mem_req",   32'(mem_req),   32'(e_mreq));
      chk("mem_be",    32'(mem_be),    32'(e_be));
      chk("mem_addr",  mem_addr,       e_maddr);
      chk("ld_valid",  32'(ld_valid),  32'(e_valid));
      if (e_valid) begin
        chk("ld_data", ld_data,        e_data);
        chk("ld_err",  32'(ld_err),    32'(e_err));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 with the unit idle; returns what was seen.
  task automatic do_load(input logic [31:0] a, input logic [1:0] w, input logic u,
                         input logic [31:0] rd, input int lat, input int hold,
                         input logic spam, input logic [31:0] exp,
                         output logic got_valid, output logic [31:0] got_data,
                         output logic got_err, output int cyc, output logic saw_mreq,
                         output logic [3:0] got_be, output logic [31:0] got_maddr);
    req_valid = 1'b1; addr = a; width = w; unsigned_ld = u;
    @(posedge clk); #1;
    cyc = 1;
    req_valid = 1'b0; addr = $urandom; width = 2'($urandom); unsigned_ld = 1'($urandom);
    saw_mreq = mem_req; got_be = mem_be; got_maddr = mem_addr;
    if (!ld_valid) begin
      // Read-strobe cycle: a stray rvalid here must be ignored
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < lat; i++) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        @(posedge clk); #1; cyc++;
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(posedge clk); #1; cyc++;
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    got_valid = ld_valid; got_data = ld_data; got_err = ld_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = spam ? 1'b1 : 1'($urandom);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", 32'(ld_valid), 32'h1);
      chk("hold_data",  ld_data, exp);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_mreq",  32'(mem_req), 32'h0);
    end
    req_valid = 1'b0; mem_rvalid = 1'b0;
    ld_ready = 1'b1;
    @(posedge clk); #1;
    ld_ready = 1'b0;
  endtask

  logic        gv, ge, sm;
  logic [31:0] gd, gm;
  logic [3:0]  gb;
  int          cy;

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_ld_valid",  32'(ld_valid),  32'h0);
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_be",    32'(mem_be),    32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_ld_data",   ld_data,        32'h0);
    chk("rst_ld_err",    32'(ld_err),    32'h0);
    @(posedge clk); #1;

    // LB / LBU at offset 3
    do_load(32'h1003, 2'b00, 1'b0, 32'h80FF1234, 0, 0, 1'b0, 32'hFFFFFF80, gv, gd, ge, cy, sm, gb, gm);
    chk("lb_maddr", gm, 32'h1000);
    chk("lb_be",    32'(gb), 32'h8);
    chk("lb_mreq",  32'(sm), 32'h1);
    chk("lb_valid", 32'(gv), 32'h1);
    chk("lb_data",  gd, 32'hFFFFFF80);
    chk("lb_lat",   32'(cy), 32'd3);
    do_load(32'h1003, 2'b00, 1'b1, 32'h80FF1234, 0, 0, 1'b0, 32'h00000080, gv, gd, ge, cy, sm, gb, gm);
    chk("lbu_data", gd, 32'h00000080);

    // LH / LHU upper half
    do_load(32'h2002, 2'b01, 1'b0, 32'hABCD0000, 1, 0, 1'b0, 32'hFFFFABCD, gv, gd, ge, cy, sm, gb, gm);
    chk("lh_be",   32'(gb), 32'hC);
    chk("lh_data", gd, 32'hFFFFABCD);
    do_load(32'h2002, 2'b01, 1'b1, 32'hABCD0000, 0, 0, 1'b0, 32'h0000ABCD, gv, gd, ge, cy, sm, gb, gm);
    chk("lhu_data", gd, 32'h0000ABCD);

    // LW with data two cycles late
    do_load(32'h3000, 2'b10, 1'b0, 32'hDEADBEEF, 2, 0, 1'b0, 32'hDEADBEEF, gv, gd, ge, cy, sm, gb, gm);
    chk("lw_be",   32'(gb), 32'hF);
    chk("lw_data", gd, 32'hDEADBEEF);
    chk("lw_lat",  32'(cy), 32'd5);

    // Result held while write-back stalls; new requests refused
    do_load(32'h5001, 2'b00, 1'b0, 32'h00007F00, 0, 3, 1'b1, 32'h0000007F, gv, gd, ge, cy, sm, gb, gm);
    chk("hold_first", gd, 32'h0000007F);

    // Misaligned word
    do_load(32'h4002, 2'b10, 1'b0, 32'h11223344, 0, 0, 1'b0,
`ifdef LOAD_MISALIGN_CHK_EN
            32'h0,
`else
            32'h11223344,
`endif
            gv, gd, ge, cy, sm, gb, gm);
    chk("mis_valid", 32'(gv), 32'h1);
    chk("mis_maddr", gm, 32'h4000);
`ifdef LOAD_MISALIGN_CHK_EN
    chk("mis_mreq", 32'(sm), 32'h0);
    chk("mis_err",  32'(ge), 32'h1);
    chk("mis_data", gd, 32'h0);
    chk("mis_lat",  32'(cy), 32'd1);
`else
    chk("mis_mreq", 32'(sm), 32'h1);
    chk("mis_be",   32'(gb), 32'hF);
    chk("mis_err",  32'(ge), 32'h0);
    chk("mis_data", gd, 32'h11223344);
`endif

    // Reset while waiting for data, then a late rvalid
    req_valid = 1'b1; addr = 32'h6000; width = 2'b10; unsigned_ld = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("wrst_ready", 32'(req_ready), 32'h1);
    chk("wrst_maddr", mem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("wrst_valid", 32'(ld_valid), 32'h0);
    chk("wrst_ready2", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    // Randomized loads
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra, rd, ex;
      logic [1:0]  rw;
      logic        ru, rb;
      ra = $urandom; rd = $urandom; rw = 2'($urandom); ru = 1'($urandom);
      rb = ref_bad(ra, rw);
      ex = rb ? 32'h0 : ref_load(ra, rw, ru, rd);
      do_load(ra, rw, ru, rd, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, ex,
              gv, gd, ge, cy, sm, gb, gm);
      chk("rnd_valid", 32'(gv), 32'h1);
      chk("rnd_data",  gd, ex);
      chk("rnd_err",   32'(ge), 32'(rb));
      repeat ($urandom_range(0, 2)) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
